button_conditioner: RTL
=======================

# button_conditioner

Multi-channel successor to the single-button debouncer: synchronises, debounces and classifies N asynchronous push-button inputs. Each channel produces a clean level plus single-cycle press, release, long-press and auto-repeat events. It sits between the board pins and the traffic-light controller's pedestrian and override request logic, so the controller sees event pulses rather than raw levels.

## Interface
- N_CH, 4: number of independent button channels (≥1).
- CYCLES, 1_000_000: consecutive stable cycles required to accept a level change (≥1; 20 ms at 50 MHz).
- LONG_CYCLES, 100_000_000: cycles the debounced level must stay pressed before a long-press event (≥1; 2 s).
- REPEAT_CYCLES, 0: auto-repeat period after a long press; 0 disables repeat.
- ACTIVE_LOW, 0: 1 means a pressed button drives din low; inversion is applied after synchronisation.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  N_CH  raw asynchronous button inputs.
- level  output  N_CH  debounced level, 1 = pressed.
- press_pulse  output  N_CH  one-cycle pulse on each accepted press.
- release_pulse  output  N_CH  one-cycle pulse on each accepted release.
- long_pulse  output  N_CH  one-cycle pulse when a press reaches LONG_CYCLES.
- repeat_pulse  output  N_CH  one-cycle pulse every REPEAT_CYCLES while in long hold.
- long_held  output  N_CH  high from the long_pulse cycle until release is accepted.

## Operation
- Each channel runs independently. Channels share no state, and simultaneous events on different channels never interact.
- Each channel uses a 2-FF synchroniser (s1, s2), then polarity correction to produce raw = s2 ^ ACTIVE_LOW.
- Debounce counter dcnt:
  - dcnt clears whenever raw == level.
  - While raw != level, dcnt increments.
  - When raw has differed from level for CYCLES consecutive cycles, level takes raw and dcnt clears.
  - A single-cycle return to raw == level (a bounce) restarts the count from 0.
- Per-channel FSM states are RELEASED, PRESSED and LONG.
  - RELEASED → PRESSED on accepted press. press_pulse=1 in the first cycle level reads 1. Hold counter hcnt clears.
  - PRESSED: hcnt increments each cycle. When level has read 1 for LONG_CYCLES cycles, go to LONG, with long_pulse=1 and long_held=1 in that cycle. The repeat counter rcnt clears.
  - LONG: if REPEAT_CYCLES≠0, repeat_pulse=1 every REPEAT_CYCLES cycles after long_pulse. rcnt wraps to 0 on each pulse. No repeat pulse coincides with long_pulse.
  - PRESSED or LONG → RELEASED on accepted release. release_pulse=1 in the first cycle level reads 0. long_held drops in that same cycle, and hcnt/rcnt clear.
  - If release is accepted in the same cycle hcnt would reach LONG_CYCLES, release wins and long_pulse is not emitted. The same rule applies to repeat_pulse in LONG: release wins.
- Counter widths:
  - dcnt is $clog2(CYCLES+1).
  - hcnt is $clog2(LONG_CYCLES+1), and saturates in LONG.
  - rcnt is $clog2(REPEAT_CYCLES+1), with a minimum width of 1.
  - No counter wraps except rcnt at REPEAT_CYCLES.
- Reset, at any time including mid-count or mid-hold:
  - s1, s2, level, all counters and all pulses clear to 0; the FSM goes to RELEASED.
  - If a button is held through reset deassertion, it is reported as a fresh press CYCLES+2 cycles later.

## Timing
- All outputs are registered, and all reset values are 0.
- Latency from a din change to level, and to press_pulse or release_pulse: 2 synchroniser cycles + CYCLES = CYCLES+2 clocks, counting from the first clk edge that samples the new value.
- long_pulse follows press_pulse by exactly LONG_CYCLES clocks.
- repeat_pulse k follows long_pulse by k·REPEAT_CYCLES clocks.
- Every pulse output is exactly 1 cycle wide. The minimum spacing between press_pulse and release_pulse on one channel is CYCLES clocks.

## Structure
- Package btn_pkg holds:
  - the btn_state_e enum (RELEASED, PRESSED, LONG);
  - the localparam width function wrapping $clog2 with a minimum of 1.
- Sub-module btn_channel implements one channel: synchroniser, debounce, FSM and counters, with scalar ports.
- button_conditioner is a generate loop of N_CH btn_channel instances.

## Test plan
Use CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, N_CH=4 unless stated.
- Clean press on ch0 at cycle 0:
  - press_pulse[0] at cycle 6, level[0]=1 from cycle 6;
  - long_pulse[0] and long_held[0]=1 at cycle 16;
  - repeat_pulse[0] at 19, 22, 25.
  - Release accepted at cycle 30 gives release_pulse[0]=1 and long_held[0]=0 in that cycle.
- Bounce: din toggles 1,0,1,0 every 2 cycles, then holds 1.
  - Exactly one press_pulse, CYCLES+2=6 cycles after the final 0→1 edge.
  - level never glitches.
- Short press: held for 8 debounced cycles.
  - press_pulse and release_pulse each appear once.
  - No long_pulse and no repeat_pulse.
- ACTIVE_LOW=1 with din idle at 1: no events. Driving din=0 gives press_pulse 6 cycles later.
- Reset mid-hold: assert rst_n=0 during LONG.
  - All outputs are 0 in the reset cycle.
  - With the button still held after deassertion, press_pulse occurs 6 cycles later and long_pulse 10 cycles after that.
- Simultaneous press on ch1 and ch3 with ch2 bouncing:
  - Ch1 and ch3 pulse in the same cycle.
  - Ch2 outputs follow its own stimulus only.
- With REPEAT_CYCLES=0, holding the button for 50 cycles produces long_pulse once and no repeat_pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioning blocks.
package btn_pkg;

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      PRESSED  = 2'd1,
      LONG     = 2'd2
   } btn_state_e;

   // Bits needed to hold values 0..max_val, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(64'(max_val) + 64'd1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce counter and
// RELEASED/PRESSED/LONG classifier with registered event pulses.
module btn_channel
   import btn_pkg::*;
#(
   parameter int unsigned CYCLES        = 1_000_000,
   parameter int unsigned LONG_CYCLES   = 100_000_000,
   parameter int unsigned REPEAT_CYCLES = 0,
   parameter bit          ACTIVE_LOW    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic long_held
);

   localparam int unsigned DW = cnt_width(CYCLES);
   localparam int unsigned HW = cnt_width(LONG_CYCLES);
   localparam int unsigned RW = cnt_width(REPEAT_CYCLES);

   localparam logic [DW-1:0] D_MAX = DW'(CYCLES);
   localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES);
   localparam logic [RW-1:0] R_MAX = RW'(REPEAT_CYCLES);

   logic          s1, s2, raw;
   logic [DW-1:0] dcnt, dcnt_d, dcnt_inc;
   logic          level_d, accept, rise, fall;

   btn_state_e    state, state_d;
   logic [HW-1:0] hcnt, hcnt_d, hcnt_inc;
   logic [RW-1:0] rcnt, rcnt_d, rcnt_inc;
   logic          press_d, release_d, long_d, repeat_d, held_d;

   // Two-stage synchroniser for the asynchronous pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

   assign raw = s2 ^ ACTIVE_LOW;

   // Debounce: accept raw once it has disagreed with level for CYCLES cycles.
   always_comb begin
      dcnt_inc = dcnt + DW'(1);
      dcnt_d   = '0;
      accept   = 1'b0;
      level_d  = level;
      if (raw != level) begin
         if (dcnt_inc == D_MAX) begin
            accept  = 1'b1;
            level_d = raw;
         end else begin
            dcnt_d = dcnt_inc;
         end
      end
   end

   assign rise = accept & raw;
   assign fall = accept & ~raw;

   // Classifier next state; an accepted release pre-empts long/repeat events.
   always_comb begin
      state_d   = state;
      hcnt_inc  = hcnt + HW'(1);
      rcnt_inc  = rcnt + RW'(1);
      hcnt_d    = hcnt;
      rcnt_d    = rcnt;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      held_d    = long_held;
      unique case (state)
         RELEASED: begin
            if (rise) begin
               state_d = PRESSED;
               press_d = 1'b1;
               hcnt_d  = '0;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_d   = RELEASED;
               release_d = 1'b1;
               held_d    = 1'b0;
               hcnt_d    = '0;
               rcnt_d    = '0;
            end else if (hcnt_inc == H_MAX) begin
               state_d = LONG;
               long_d  = 1'b1;
               held_d  = 1'b1;
               hcnt_d  = hcnt_inc;
               rcnt_d  = '0;
            end else begin
               hcnt_d = hcnt_inc;
            end
         end
         LONG: begin
            if (fall) begin
               state_d   = RELEASED;
               release_d = 1'b1;
               held_d    = 1'b0;
               hcnt_d    = '0;
               rcnt_d    = '0;
            end else if (REPEAT_CYCLES != 0) begin
               if (rcnt_inc == R_MAX) begin
                  repeat_d = 1'b1;
                  rcnt_d   = '0;
               end else begin
                  rcnt_d = rcnt_inc;
               end
            end
         end
         default: begin
            state_d = RELEASED;
            held_d  = 1'b0;
            hcnt_d  = '0;
            rcnt_d  = '0;
         end
      endcase
   end

   // Register debounce, classifier state and all outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt          <= '0;
         level         <= 1'b0;
         state         <= RELEASED;
         hcnt          <= '0;
         rcnt          <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         long_held     <= 1'b0;
      end else begin
         dcnt          <= dcnt_d;
         level         <= level_d;
         state         <= state_d;
         hcnt          <= hcnt_d;
         rcnt          <= rcnt_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
         long_pulse    <= long_d;
         repeat_pulse  <= repeat_d;
         long_held     <= held_d;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// N independent debounced push-button channels with event pulses.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned CYCLES        = 1_000_000,
   parameter int unsigned LONG_CYCLES   = 100_000_000,
   parameter int unsigned REPEAT_CYCLES = 0,
   parameter bit          ACTIVE_LOW    = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] din,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_pulse,
   output logic [N_CH-1:0] repeat_pulse,
   output logic [N_CH-1:0] long_held
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_channel #(
         .CYCLES        (CYCLES),
         .LONG_CYCLES   (LONG_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES),
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .din           (din[i]),
         .level         (level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .long_pulse    (long_pulse[i]),
         .repeat_pulse  (repeat_pulse[i]),
         .long_held     (long_held[i])
      );
   end

endmodule
